// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch sequencer driving an external PC register.
// Runs a req/ack handshake with instruction memory, presents fetched words to IF/ID,
// absorbs IF/ID stalls and branch/jump redirects (including ones that arrive while
// a memory request is still outstanding).
//
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   pc_current               PC register output (fetch address)
//   pc_next, pc_load         PC register data input and load enable
//   imem_req, imem_addr      fetch request and address to instruction memory
//   imem_ack, imem_data      one-cycle acknowledge with the returned word
//   stall                    IF/ID cannot accept an instruction
//   redirect, redirect_target taken branch/jump pulse and destination
//   if_valid, if_instr, if_pc registered instruction presented to IF/ID
module fetch_sequencer #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] INC      = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pc_current,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_load,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc
);

  typedef enum logic [1:0] {StInit, StFetch, StHold, StDrain} state_e;

  state_e           state_q, state_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  // Redirect destination remembered while a wrong-path request drains.
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StInit;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    pend_target_d = pend_target_q;
    unique case (state_q)
      StInit: begin
        if_valid_d = 1'b0;
        state_d    = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          if (redirect) begin
            // Returned word is on the wrong path; refetch from the target.
            state_d = StFetch;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = imem_data;
            if_pc_d    = pc_current;
            state_d    = StHold;
          end
        end else if (redirect) begin
          // Request cannot be withdrawn; wait for its ack before retargeting.
          pend_target_d = redirect_target;
          state_d       = StDrain;
        end
      end
      StHold: begin
        // Redirect wins over stall.
        if (redirect || !stall) begin
          if_valid_d = 1'b0;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        if (redirect) pend_target_d = redirect_target;
        if (imem_ack) state_d = StFetch;
      end
      default: state_d = StInit;
    endcase
  end

  // Output logic.
  always_comb begin
    pc_load  = 1'b0;
    pc_next  = RESET_PC;
    imem_req = 1'b0;
    if (!clr) begin
      unique case (state_q)
        StInit: begin
          pc_load = 1'b1;
          pc_next = redirect ? redirect_target : RESET_PC;
        end
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pc_load = 1'b1;
            pc_next = redirect ? redirect_target : pc_current + INC;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_target;
          end
        end
        StDrain: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pc_load = 1'b1;
            pc_next = redirect ? redirect_target : pend_target_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_current;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer with an external PC register, a
// variable-latency memory responder and a transaction-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] ResetPc = 32'h0;
  localparam logic [31:0] Inc     = 32'h4;

  logic        clk;
  logic        clr;
  logic [31:0] pc_current, pc_next, imem_addr, imem_data, redirect_target;
  logic [31:0] if_instr, if_pc;
  logic        pc_load, imem_req, imem_ack, stall, redirect, if_valid;

  fetch_sequencer #(
    .WIDTH   (32),
    .RESET_PC(ResetPc),
    .INC     (Inc)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .pc_current     (pc_current),
    .pc_next        (pc_next),
    .pc_load        (pc_load),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register, deliberately not reset.
  initial pc_current = 32'hDEAD_0000;
  always_ff @(posedge clk) if (pc_load) pc_current <= pc_next;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL cycle %0d %s: got %h expected %h", cyc, tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: what the sequencer is doing, in transaction terms.
  bit          m_init, m_valid, m_wrong_path;
  logic [31:0] m_instr, m_pc, m_fetch_pc, m_pend;
  bit          e_load, e_req;
  logic [31:0] e_next, addr_now;

  // Memory responder bookkeeping.
  bit mem_busy;
  int lat, cnt;

  initial begin
    clr = 1'b1; imem_ack = 1'b0; imem_data = '0; stall = 1'b0;
    redirect = 1'b0; redirect_target = '0;
    mem_busy = 0; lat = 0; cnt = 0;
    m_init = 1; m_valid = 0; m_wrong_path = 0;
    m_instr = '0; m_pc = '0; m_fetch_pc = '0; m_pend = '0;

    for (int i = 0; i < 3000; i++) begin
      cyc = i;
      @(posedge clk);
      #1;
      if (i < 2)        clr = 1'b1;
      else if (i < 200) clr = 1'b0;
      else              clr = ($urandom_range(99) == 0);
      #1;

      // Memory: pick a latency when a new request appears, ack when it expires.
      if (clr) begin
        mem_busy = 0;
        imem_ack = 1'b0;
      end else if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1;
          cnt = 0;
          if (i < 40)       lat = 0;
          else if (i < 80)  lat = 3;
          else if (i < 200) lat = $urandom_range(1);
          else              lat = $urandom_range(3);
        end
        imem_ack = (cnt == lat);
        cnt++;
        if (imem_ack) mem_busy = 0;
      end else begin
        imem_ack = 1'b0;
      end
      imem_data = imem_ack ? mem_word(imem_addr) : $urandom;

      if (i < 80)       stall = 1'b0;
      else if (i < 200) stall = $urandom_range(1);
      else              stall = ($urandom_range(9) < 3);
      redirect = (i >= 200) && ($urandom_range(99) < 15);
      redirect_target = $urandom & 32'hFFFF_FFFC;
      #1;

      // Expected combinational outputs for this cycle.
      e_load = 0; e_next = ResetPc; e_req = 0;
      if (clr) begin
        e_load = 0;
      end else if (m_init) begin
        e_load = 1;
        e_next = redirect ? redirect_target : ResetPc;
      end else if (m_valid) begin
        if (redirect) begin
          e_load = 1;
          e_next = redirect_target;
        end
      end else begin
        e_req = 1;
        if (imem_ack) begin
          e_load = 1;
          if (redirect)          e_next = redirect_target;
          else if (m_wrong_path) e_next = m_pend;
          else                   e_next = m_fetch_pc + Inc;
        end
      end

      check("pc_load", {31'b0, pc_load}, {31'b0, e_load});
      check("pc_next", pc_next, e_next);
      check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      check("imem_addr_is_pc", imem_addr, pc_current);
      if (e_req) check("imem_addr", imem_addr, m_fetch_pc);
      check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      check("if_instr", if_instr, m_instr);
      check("if_pc", if_pc, m_pc);
      // Every word handed to IF/ID must be the memory contents at its address.
      if (if_valid && !stall) check("transfer_instr", if_instr, mem_word(if_pc));

      // Advance the model across the coming edge.
      addr_now = m_fetch_pc;
      if (clr) begin
        m_init = 1; m_valid = 0; m_wrong_path = 0;
        m_instr = '0; m_pc = '0; m_pend = '0;
      end else begin
        if (e_load) m_fetch_pc = e_next;
        if (m_init) begin
          m_init = 0;
        end else if (m_valid) begin
          if (redirect || !stall) m_valid = 0;
        end else if (imem_ack) begin
          if (!redirect && !m_wrong_path) begin
            m_valid = 1;
            m_instr = imem_data;
            m_pc    = addr_now;
          end
          m_wrong_path = 0;
        end else if (redirect) begin
          m_wrong_path = 1;
          m_pend = redirect_target;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
